mul_job_queue: RTL and testbench

Host-side job queue and bus master for the `gpioemu` multiplier peripheral. Buffers operand pairs written by the host, drives the multiplier's slave port (write A1, write A2, start, poll status, read W and L) one job at a time, and buffers results for host readout. Sits directly upstream and downstream of `gpioemu`: it replaces direct host access to addresses 0x0380–0x03A0.

---
 rtl/mul_job_queue_if.sv | 25 ++
 rtl/mul_job_queue.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_mul_job_queue.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_job_queue_if.sv
// Host register port and multiplier slave-bus signals of mul_job_queue.
// master = the job queue itself, slave = host plus multiplier side.
interface mul_job_queue_if;
    logic [15:0] h_addr;
    logic        h_wr;
    logic        h_rd;
    logic [31:0] h_wdata;
    logic [31:0] h_rdata;
    logic [15:0] m_saddress;
    logic        m_swr;
    logic        m_srd;
    logic [31:0] m_sdata_in;
    logic [31:0] m_sdata_out;
    logic        busy;

    modport master (
        input  h_addr, h_wr, h_rd, h_wdata, m_sdata_out,
        output h_rdata, m_saddress, m_swr, m_srd, m_sdata_in, busy
    );

    modport slave (
        output h_addr, h_wr, h_rd, h_wdata, m_sdata_out,
        input  h_rdata, m_saddress, m_swr, m_srd, m_sdata_in, busy
    );
endinterface

// File: rtl/mul_job_queue.sv
// Operand/result FIFOs plus a bus-master sequencer driving one gpioemu multiplier job at a time.
// Optional macro MULQ_TIMEOUT_EN: abandon a job after POLL_MAX failed status polls.
module mul_job_queue #(
    parameter int DEPTH      = 4,
    parameter int START_WAIT = 8,
    parameter int POLL_MAX   = 16
) (
    input  logic            clk,
    input  logic            n_reset,
    mul_job_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(START_WAIT + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(START_WAIT - 1);

    localparam logic [15:0] A_OP_A   = 16'h0400;
    localparam logic [15:0] A_OP_B   = 16'h0408;
    localparam logic [15:0] A_RES_W  = 16'h0410;
    localparam logic [15:0] A_RES_L  = 16'h0418;
    localparam logic [15:0] A_STATUS = 16'h0420;
    localparam logic [15:0] M_A1     = 16'h0380;
    localparam logic [15:0] M_A2     = 16'h0388;
    localparam logic [15:0] M_W      = 16'h0390;
    localparam logic [15:0] M_L      = 16'h0398;
    localparam logic [15:0] M_CTRL   = 16'h03A0;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A1, S_WR_A2, S_WR_START, S_WAIT, S_POLL, S_RD_W, S_RD_L, S_PUSH
    } state_e;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || START_WAIT < 1 || POLL_MAX < 1)
    begin : g_bad_param
        $error("mul_job_queue: unsupported parameter set");
    end

    logic [47:0]   op_mem_q  [DEPTH];
    logic [55:0]   res_mem_q [DEPTH];
    logic [AW-1:0] op_wp_q, op_wp_d, op_rp_q, op_rp_d;
    logic [AW-1:0] res_wp_q, res_wp_d, res_rp_q, res_rp_d;
    logic [CW-1:0] op_cnt_q, op_cnt_d, res_cnt_q, res_cnt_d;
    logic [23:0]   stage_q, stage_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic [31:0]   h_rdata_q, h_rdata_d;
    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [47:0]   job_q, job_d;
    logic [31:0]   res_w_q, res_w_d;
    logic [23:0]   res_l_q, res_l_d;
    logic [15:0]   m_saddress_q, m_saddress_d;
    logic          m_swr_q, m_swr_d, m_srd_q, m_srd_d;
    logic [31:0]   m_sdata_in_q, m_sdata_in_d;
    logic          busy_q, busy_d;
`ifdef MULQ_TIMEOUT_EN
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
    logic [PW-1:0] poll_q, poll_d;
    logic          tmo_q, tmo_d;
`endif
    logic        tmo_bit;
    logic        op_full, op_empty, res_full, res_empty;
    logic        wr_op_a, wr_op_b, rd_res_w, rd_res_l, wr_stat;
    logic        launch, op_push, op_pop, res_push, res_pop, clr_sticky;
    logic [31:0] status;
    logic        unused_wdata;

    assign unused_wdata = ^bus.h_wdata[31:24];

    // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
    always_comb begin
        op_full    = (op_cnt_q == FULL_CNT);
        op_empty   = (op_cnt_q == '0);
        res_full   = (res_cnt_q == FULL_CNT);
        res_empty  = (res_cnt_q == '0);
        wr_op_a    = bus.h_wr && (bus.h_addr == A_OP_A);
        wr_op_b    = bus.h_wr && (bus.h_addr == A_OP_B);
        wr_stat    = bus.h_wr && (bus.h_addr == A_STATUS);
        rd_res_w   = bus.h_rd && (bus.h_addr == A_RES_W);
        rd_res_l   = bus.h_rd && (bus.h_addr == A_RES_L);
        clr_sticky = wr_stat && bus.h_wdata[0];
        launch     = (state_q == S_IDLE) && !op_empty && !res_full;
        op_pop     = launch;
        // A full FIFO still accepts a pair when the sequencer pops in the same cycle.
        op_push    = wr_op_b && (!op_full || op_pop);
        res_push   = (state_q == S_PUSH);
        res_pop    = rd_res_w && !res_empty;
`ifdef MULQ_TIMEOUT_EN
        tmo_bit    = tmo_q;
`else
        tmo_bit    = 1'b0;
`endif
        status = {16'h0, 8'(res_cnt_q), tmo_bit, udf_q, ovf_q, busy_q,
                  res_empty, res_full, op_empty, op_full};
    end

    always_comb begin
        op_wp_d   = op_wp_q + AW'(op_push);
        op_rp_d   = op_rp_q + AW'(op_pop);
        op_cnt_d  = op_cnt_q + CW'(op_push) - CW'(op_pop);
        res_wp_d  = res_wp_q + AW'(res_push);
        res_rp_d  = res_rp_q + AW'(res_pop);
        res_cnt_d = res_cnt_q + CW'(res_push) - CW'(res_pop);
        stage_d   = wr_op_a ? bus.h_wdata[23:0] : stage_q;
        ovf_d     = (clr_sticky ? 1'b0 : ovf_q) | (wr_op_b && op_full && !op_pop);
        udf_d     = (clr_sticky ? 1'b0 : udf_q) | ((rd_res_w || rd_res_l) && res_empty);
        h_rdata_d = h_rdata_q;
        if (bus.h_rd) begin
            case (bus.h_addr)
                A_RES_W:  h_rdata_d = res_empty ? 32'h0 : res_mem_q[res_rp_q][55:24];
                A_RES_L:  h_rdata_d = res_empty ? 32'h0 : {8'h0, res_mem_q[res_rp_q][23:0]};
                A_STATUS: h_rdata_d = status;
                default:  h_rdata_d = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wait_d  = wait_q;
        job_d   = job_q;
        res_w_d = res_w_q;
        res_l_d = res_l_q;
`ifdef MULQ_TIMEOUT_EN
        poll_d  = poll_q;
        tmo_d   = clr_sticky ? 1'b0 : tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_WR_A1;
                    phase_d = 2'd0;
                    job_d   = op_mem_q[op_rp_q];
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_POLL;
                    wait_d  = '0;
`ifdef MULQ_TIMEOUT_EN
                    poll_d  = '0;
`endif
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_PUSH: state_d = S_IDLE;
            default: begin
                if (phase_q != 2'd2) begin
                    phase_d = phase_q + 2'd1;
                end else begin
                    phase_d = 2'd0;
                    case (state_q)
                        S_WR_A1:    state_d = S_WR_A2;
                        S_WR_A2:    state_d = S_WR_START;
                        S_WR_START: state_d = S_WAIT;
                        S_POLL: begin
                            if (bus.m_sdata_out[1:0] == 2'b11) begin
                                state_d = S_RD_W;
                            end
`ifdef MULQ_TIMEOUT_EN
                            else if (poll_q == POLL_LAST) begin
                                state_d = S_IDLE;
                                tmo_d   = 1'b1;
                            end else begin
                                poll_d = poll_q + 1'b1;
                            end
`endif
                        end
                        S_RD_W: begin
                            res_w_d = bus.m_sdata_out;
                            state_d = S_RD_L;
                        end
                        S_RD_L: begin
                            res_l_d = bus.m_sdata_out[23:0];
                            state_d = S_PUSH;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase

        // Bus outputs are registered from the upcoming state/phase so they line up with it.
        m_saddress_d = '0;
        m_sdata_in_d = '0;
        m_swr_d      = 1'b0;
        m_srd_d      = 1'b0;
        case (state_d)
            S_WR_A1: begin
                m_saddress_d = M_A1;
                m_sdata_in_d = {8'h0, job_d[47:24]};
                m_swr_d      = (phase_d == 2'd1);
            end
            S_WR_A2: begin
                m_saddress_d = M_A2;
                m_sdata_in_d = {8'h0, job_d[23:0]};
                m_swr_d      = (phase_d == 2'd1);
            end
            S_WR_START: begin
                m_saddress_d = M_CTRL;
                m_swr_d      = (phase_d == 2'd1);
            end
            S_POLL: begin
                m_saddress_d = M_CTRL;
                m_srd_d      = (phase_d == 2'd1);
            end
            S_RD_W: begin
                m_saddress_d = M_W;
                m_srd_d      = (phase_d == 2'd1);
            end
            S_RD_L: begin
                m_saddress_d = M_L;
                m_srd_d      = (phase_d == 2'd1);
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: FIFO storage has no reset; pointers and counts alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (op_push)  op_mem_q[op_wp_q]   <= {stage_q, bus.h_wdata[23:0]};
        if (res_push) res_mem_q[res_wp_q] <= {res_w_q, res_l_q};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            op_wp_q      <= '0;
            op_rp_q      <= '0;
            op_cnt_q     <= '0;
            res_wp_q     <= '0;
            res_rp_q     <= '0;
            res_cnt_q    <= '0;
            stage_q      <= '0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            h_rdata_q    <= '0;
            state_q      <= S_IDLE;
            phase_q      <= '0;
            wait_q       <= '0;
            job_q        <= '0;
            res_w_q      <= '0;
            res_l_q      <= '0;
            m_saddress_q <= '0;
            m_swr_q      <= 1'b0;
            m_srd_q      <= 1'b0;
            m_sdata_in_q <= '0;
            busy_q       <= 1'b0;
`ifdef MULQ_TIMEOUT_EN
            poll_q       <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            op_wp_q      <= op_wp_d;
            op_rp_q      <= op_rp_d;
            op_cnt_q     <= op_cnt_d;
            res_wp_q     <= res_wp_d;
            res_rp_q     <= res_rp_d;
            res_cnt_q    <= res_cnt_d;
            stage_q      <= stage_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            h_rdata_q    <= h_rdata_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            wait_q       <= wait_d;
            job_q        <= job_d;
            res_w_q      <= res_w_d;
            res_l_q      <= res_l_d;
            m_saddress_q <= m_saddress_d;
            m_swr_q      <= m_swr_d;
            m_srd_q      <= m_srd_d;
            m_sdata_in_q <= m_sdata_in_d;
            busy_q       <= busy_d;
`ifdef MULQ_TIMEOUT_EN
            poll_q       <= poll_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign bus.h_rdata    = h_rdata_q;
    assign bus.m_saddress = m_saddress_q;
    assign bus.m_swr      = m_swr_q;
    assign bus.m_srd      = m_srd_q;
    assign bus.m_sdata_in = m_sdata_in_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mul_job_queue.sv
// Scoreboard bench for mul_job_queue with a small gpioemu multiplier model on the slave bus.
// Host reads queue their expected value; a monitor compares h_rdata the cycle after each read.
module tb_mul_job_queue;
    localparam logic [15:0] OP_A   = 16'h0400;
    localparam logic [15:0] OP_B   = 16'h0408;
    localparam logic [15:0] RES_W  = 16'h0410;
    localparam logic [15:0] RES_L  = 16'h0418;
    localparam logic [15:0] STATUS = 16'h0420;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    mul_job_queue_if ifc();

    mul_job_queue #(.DEPTH(4), .START_WAIT(8), .POLL_MAX(16)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (ifc.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", nm, got, exp);
        end
    endtask

    // gpioemu model: status 01 while computing or stalled, 11 once the product is ready.
    logic [23:0] g_a1 = '0, g_a2 = '0;
    logic [31:0] g_w = '0, g_l = '0;
    logic [47:0] g_prod;
    int          g_delay = 0;
    bit          g_started = 0;
    bit          stall = 0;
    logic [31:0] l_tab[$];

    assign g_prod = {24'h0, g_a1} * {24'h0, g_a2};

    always @(posedge clk) begin
        if (ifc.m_swr) begin
            case (ifc.m_saddress)
                16'h0380: g_a1 <= ifc.m_sdata_in[23:0];
                16'h0388: g_a2 <= ifc.m_sdata_in[23:0];
                16'h03A0: begin
                    g_started <= 1'b1;
                    g_delay   <= 4;
                    g_w       <= g_prod[31:0];
                    g_l       <= (l_tab.size() > 0) ? l_tab.pop_front() : 32'hDEAD;
                end
                default: ;
            endcase
        end else if (g_delay > 0) begin
            g_delay <= g_delay - 1;
        end
    end

    always_comb begin
        case (ifc.m_saddress)
            16'h03A0: ifc.m_sdata_out = {30'h0, (g_started && !stall && g_delay == 0) ? 2'b11 : 2'b01};
            16'h0390: ifc.m_sdata_out = g_w;
            16'h0398: ifc.m_sdata_out = g_l;
            default:  ifc.m_sdata_out = 32'h0;
        endcase
    end

    // Strobes must never overlap and never sit on consecutive cycles.
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (ifc.m_swr || ifc.m_srd)
            check("bus_strobe", {30'h0, prev_strobe, ifc.m_swr & ifc.m_srd}, 32'h0);
        prev_strobe <= ifc.m_swr | ifc.m_srd;
    end

    // Scoreboard monitor.
    logic [31:0] exp_q[$];
    string       name_q[$];
    initial forever begin
        @(posedge clk);
        if (ifc.h_rd && n_reset) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underrun: read returned %08h with nothing expected", ifc.h_rdata);
            end else begin
                check(name_q.pop_front(), ifc.h_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        ifc.h_addr  = a;
        ifc.h_wdata = d;
        ifc.h_wr    = 1'b1;
        @(negedge clk);
        ifc.h_wr    = 1'b0;
    endtask

    task automatic host_rd(input logic [15:0] a, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        ifc.h_addr = a;
        ifc.h_rd   = 1'b1;
        @(negedge clk);
        ifc.h_rd   = 1'b0;
    endtask

    // Counts negedges until busy has risen and fallen again.
    task automatic wait_idle(input int budget, input string nm, output int cycles);
        bit seen = 0;
        bit done = 0;
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (ifc.busy) seen = 1;
            else if (seen) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: busy did not fall within %0d cycles", nm, budget);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_h_rdata"}, ifc.h_rdata, 32'h0);
        check({nm, "_m_ctl"}, {ifc.m_saddress, 13'h0, ifc.m_swr, ifc.m_srd, ifc.busy}, 32'h0);
        check({nm, "_m_data"}, ifc.m_sdata_in, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stalled-multiplier vectors: the first pair goes in flight, four fill the FIFO, the last is dropped.
    logic [23:0] ov_a [6] = '{24'd1, 24'd3, 24'd5, 24'd7, 24'd9, 24'd11};
    logic [23:0] ov_b [6] = '{24'd2, 24'd4, 24'd6, 24'd8, 24'd10, 24'd12};
    logic [31:0] ov_w [5] = '{32'd2, 32'd12, 32'd30, 32'd56, 32'd90};

    initial begin
        int lat;
        int n;
        ifc.h_addr  = '0;
        ifc.h_wdata = '0;
        ifc.h_wr    = 1'b0;
        ifc.h_rd    = 1'b0;

        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        n_reset = 1'b1;
        @(negedge clk);
        host_rd(STATUS, 32'h0000_000A, "rst_status");

        // 3 * 5, multiplier reports L=2; upper write bits must be ignored.
        l_tab.push_back(32'd2);
        host_wr(OP_A, 32'hAB00_0003);
        host_wr(OP_B, 32'h0000_0005);
        wait_idle(100, "job1_idle", lat);
        check("job1_latency_from_push", lat, 32'd28);
        host_rd(STATUS, 32'h0000_0102, "job1_status");
        host_rd(RES_L, 32'd2, "job1_res_l");
        host_rd(RES_W, 32'd15, "job1_res_w");
        host_rd(STATUS, 32'h0000_000A, "job1_drained");

        // Widest operands.
        l_tab.push_back(32'd8);
        host_wr(OP_A, 32'h00FF_FFFF);
        host_wr(OP_B, 32'hFFFF_FFFF);
        wait_idle(100, "job2_idle", lat);
        host_rd(RES_L, 32'd8, "job2_res_l");
        host_rd(RES_W, 32'hFE00_0001, "job2_res_w");

        // Underflow on both result registers, then sticky clear.
        host_rd(RES_W, 32'h0, "udf_res_w");
        host_rd(STATUS, 32'h0000_004A, "udf_status_w");
        host_wr(STATUS, 32'h1);
        host_rd(STATUS, 32'h0000_000A, "udf_clear_w");
        host_rd(RES_L, 32'h0, "udf_res_l");
        host_rd(STATUS, 32'h0000_004A, "udf_status_l");
        host_wr(STATUS, 32'h1);
        host_rd(STATUS, 32'h0000_000A, "udf_clear_l");

`ifndef MULQ_TIMEOUT_EN
        stall = 1;
        for (int i = 0; i < 5; i++) l_tab.push_back(32'd100 + i);
        for (int i = 0; i < 6; i++) begin
            host_wr(OP_A, {8'h0, ov_a[i]});
            host_wr(OP_B, {8'h0, ov_b[i]});
        end
        host_rd(STATUS, 32'h0000_0039, "ovf_status");
        stall = 0;
        repeat (250) @(negedge clk);
        host_rd(STATUS, 32'h0000_0424, "ovf_res_full");
        for (int i = 0; i < 4; i++) host_rd(RES_W, ov_w[i], $sformatf("ovf_res_w%0d", i));
        repeat (60) @(negedge clk);
        host_rd(RES_W, ov_w[4], "ovf_res_w4");
        host_rd(STATUS, 32'h0000_002A, "ovf_drained");
        host_wr(STATUS, 32'h1);
`else
        stall = 1;
        l_tab.push_back(32'd0);
        host_wr(OP_A, 32'd4);
        host_wr(OP_B, 32'd4);
        wait_idle(200, "tmo_idle", lat);
        host_rd(STATUS, 32'h0000_008A, "tmo_status");
        host_wr(STATUS, 32'h1);
        host_rd(STATUS, 32'h0000_000A, "tmo_clear");
        stall = 0;
`endif

        // Reset while the sequencer is polling.
        stall = 1;
        l_tab.push_back(32'hBAD);
        host_wr(OP_A, 32'd2);
        host_wr(OP_B, 32'd3);
        n = 0;
        while (!(ifc.m_srd && ifc.m_saddress == 16'h03A0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("poll_reached", {31'h0, n < 200}, 32'h1);
        n_reset = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        @(negedge clk);
        n_reset = 1'b1;
        stall = 0;
        repeat (60) @(negedge clk);
        host_rd(STATUS, 32'h0000_000A, "rst_no_result");

        l_tab.push_back(32'd3);
        host_wr(OP_A, 32'd6);
        host_wr(OP_B, 32'd7);
        wait_idle(100, "job3_idle", lat);
        check("job3_latency_from_push", lat, 32'd28);
        host_rd(RES_L, 32'd3, "job3_res_l");
        host_rd(RES_W, 32'd42, "job3_res_w");
        host_rd(STATUS, 32'h0000_000A, "job3_drained");

        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
